// File: rtl/buffered_uart_tx_if.sv
// Byte-write side of the buffered UART transmitter.
// The producer drives din/wen; status and serial line come back.
interface buffered_uart_tx_if;
  logic [7:0] din;
  logic       wen;
  logic       full;
  logic       busy;
  logic       tx_out;

  modport master (
    output din,
    output wen,
    input  full,
    input  busy,
    input  tx_out
  );

  modport slave (
    input  din,
    input  wen,
    output full,
    output busy,
    output tx_out
  );
endinterface

// File: rtl/buffered_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter.
// Frames leave back-to-back while the buffer holds bytes.
module buffered_uart_tx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic clk,
  input  logic rst,
  buffered_uart_tx_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [AW-1:0] P1   = AW'(1);
  localparam logic [AW:0]   N1   = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;

  state_t        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic          tx_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bit_end;

  assign full    = (cnt_q == DEPTH);
  assign empty   = (cnt_q == '0);
  assign push    = bus.wen & ~full;
  assign bit_end = (clk_cnt_q == LAST);
  assign pop     = ~empty &
                   ((state_q == IDLE) |
                    ((state_q == STOP) & bit_end));

  assign bus.full   = full;
  assign bus.busy   = (state_q != IDLE) | ~empty;
  assign bus.tx_out = tx_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push & ~pop: cnt_d = cnt_q + N1;
      pop & ~push: cnt_d = cnt_q - N1;
      default:     cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + P1;
      if (pop)  rd_q <= rd_q + P1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q      <= 1'b1;
          clk_cnt_q <= '0;
          if (pop) begin
            sh_q    <= mem_q[rd_q];
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            idx_q     <= '0;
            tx_q      <= sh_q[0];
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + C1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + C1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            // Chain straight into the next start bit.
            if (pop) begin
              sh_q    <= mem_q[rd_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + C1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffered_uart_tx.sv
// Directed bench for buffered_uart_tx.
// Exact-edge frame checks plus a mid-bit line decoder.
module tb_buffered_uart_tx;

  localparam int N = 8;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  buffered_uart_tx_if bus ();

  buffered_uart_tx #(
    .CLKS_PER_BIT(N),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q [$];
  logic [7:0] mon_b;

  // Line decoder: samples each bit at its centre.
  always begin
    @(negedge clk);
    if (bus.tx_out === 1'b0) begin
      repeat (N / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (N) @(negedge clk);
        mon_b[i] = bus.tx_out;
      end
      repeat (N) @(negedge clk);
      rx_q.push_back(mon_b);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.din = b;
    bus.wen = 1'b1;
    @(negedge clk);
    bus.wen = 1'b0;
  endtask

  // Called at the negedge after the start-bit edge.
  task automatic check_frame(input logic [7:0] b,
                             input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_bit%0d_first", tag, k),
          32'(bus.tx_out), 32'(f[k]));
      repeat (N - 1) @(negedge clk);
      chk($sformatf("%s_bit%0d_last", tag, k),
          32'(bus.tx_out), 32'(f[k]));
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget,
                           input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_in_time"},
        32'(n < budget), 32'd1);
    repeat (N) @(negedge clk);
  endtask

  task automatic check_rx(input string tag,
                          input int first,
                          input int n);
    chk({tag, "_rx_len"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size())
        chk($sformatf("%s_rx%0d", tag, i),
            32'(rx_q[i]), 32'((first + i) & 8'hff));
    end
    rx_q.delete();
  endtask

  initial begin
    logic low_seen;
    bus.din = 8'h00;
    bus.wen = 1'b0;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("por_tx", 32'(bus.tx_out), 32'd1);
    chk("por_busy", 32'(bus.busy), 32'd0);
    chk("por_full", 32'(bus.full), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-frame, second byte still buffered
    push_byte(8'h00);
    push_byte(8'h00);
    chk("rst_start", 32'(bus.tx_out), 32'd0);
    repeat (3 * N) @(negedge clk);
    chk("rst_mid_tx", 32'(bus.tx_out), 32'd0);
    #1 rst = 1'b1;
    #1 chk("rst_async_tx", 32'(bus.tx_out), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 12 * N; i++) begin
      @(negedge clk);
      if (bus.tx_out !== 1'b1) low_seen = 1'b1;
    end
    chk("rst_no_frame", 32'(low_seen), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    rx_q.delete();

    // Burst 'A','B' back-to-back
    push_byte(8'h41);
    push_byte(8'h42);
    check_frame(8'h41, "burstA");
    check_frame(8'h42, "burstB");
    chk("burst_idle_tx", 32'(bus.tx_out), 32'd1);
    chk("burst_busy", 32'(bus.busy), 32'd0);
    repeat (N) @(negedge clk);
    check_rx("burst", 8'h41, 2);

    // Single 0x55, start one cycle after write
    push_byte(8'h55);
    chk("single_pre_tx", 32'(bus.tx_out), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check_frame(8'h55, "single");
    chk("single_busy_end", 32'(bus.busy), 32'd0);
    repeat (N) @(negedge clk);
    check_rx("single", 8'h55, 1);

    // Overflow: 20 consecutive writes
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(i));
      if (i == 15)
        chk("ovf_full_15", 32'(bus.full), 32'd0);
      if (i == 16)
        chk("ovf_full_16", 32'(bus.full), 32'd1);
    end
    chk("ovf_full_end", 32'(bus.full), 32'd1);
    wait_idle(20 * 10 * N, "ovf");
    chk("ovf_full_drained", 32'(bus.full), 32'd0);
    check_rx("ovf", 8'h00, 17);

    // Wrap-around: 3 rounds of 13 bytes
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 13; i++)
        push_byte(8'(8'h80 + r * 13 + i));
      wait_idle(15 * 10 * N, $sformatf("wrap%0d", r));
    end
    check_rx("wrap", 8'h80, 39);

    // Write during the last stop bit
    push_byte(8'hA5);
    @(negedge clk);
    repeat (9 * N + N / 2) @(negedge clk);
    chk("stopw_in_stop", 32'(bus.tx_out), 32'd1);
    push_byte(8'h0F);
    repeat (N / 2 - 1) @(negedge clk);
    if (bus.tx_out === 1'b1) @(negedge clk);
    check_frame(8'h0F, "stopw");
    wait_idle(4 * N, "stopw");
    chk("stopw_rx_len", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("stopw_rx0", 32'(rx_q[0]), 32'hA5);
      chk("stopw_rx1", 32'(rx_q[1]), 32'h0F);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/buffered_uart_tx.md
# buffered_uart_tx

Buffered UART transmitter: accepts bytes on a single-cycle write strobe into an internal FIFO and serialises them as 8N1 frames on one TX line with no gaps between frames. It sits between byte-producing logic (e.g. the RPN result formatter) and the board UART pin. Producers can push bursts of bytes on consecutive clocks without waiting on the line.

## Interface
- `CLKS_PER_BIT`, default 1085: clock cycles per UART bit. 1085 at 125 MHz is 115200 baud, 8.68 µs/bit.
- `FIFO_DEPTH`, default 16: byte capacity of the buffer; a power of two ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  8  byte to enqueue; sampled when `wen`=1.
- `wen`  in  1  write enable; each cycle high enqueues one byte.
- `tx_out`  out  1  serial line, idle high, registered.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.

## Operation
- **FIFO**
  - Circular buffer with a read pointer, a write pointer and a count (width log2(FIFO_DEPTH)+1).
  - Write: on a rising edge with `wen`=1 and `full`=0 (pre-edge), store `din` at the write pointer; the pointer wraps modulo `FIFO_DEPTH`.
  - A write while `full`=1 is silently dropped; nothing is overwritten.
  - Simultaneous write and pop: both happen and the count is unchanged.
- **Frame format**
  - Start bit 0, then data bits 0..7 LSB first, then one stop bit 1. No parity.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx_out`=1. If the FIFO is non-empty (pre-edge), pop the head byte into a shift register, set `tx_out`=0 and go to START.
  - START: hold for `CLKS_PER_BIT` cycles, then drive data bit 0 and go to DATA.
  - DATA: each bit lasts `CLKS_PER_BIT` cycles, tracked by a 3-bit index. After bit 7, drive 1 and go to STOP.
  - STOP: hold for `CLKS_PER_BIT` cycles. At the end:
    - FIFO non-empty: pop the next byte, drive 0, go directly to START, so frames are back-to-back.
    - FIFO empty: go to IDLE.
- **Bit counter**
  - Width ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on each bit boundary.
- **Ownership:** a popped byte belongs to the transmitter. Later writes never alter a frame in progress.
- **Reset** (asynchronous, any time, including mid-frame)
  - Outputs: `tx_out`=1, `full`=0, `busy`=0.
  - FIFO pointers and count go to 0, so buffered bytes are discarded.
  - FSM goes to IDLE; the counter and bit index are cleared.
  - A partially sent frame is abandoned. The line returns high immediately.

## Timing
- A write at edge E0 makes the FIFO non-empty after E0.
- With the FSM in IDLE, the pop happens at E1 = E0+1, and `tx_out` falls after E1.
- Where N = `CLKS_PER_BIT`, bit k (start=0, data0=1, …, stop=9) occupies edges [E1+k·N, E1+(k+1)·N).
- One frame is exactly 10·N cycles. The next frame's start bit begins at E1+10·N if the FIFO is non-empty then.
- `full` and `busy` are combinational from the registered count and state, valid the cycle after the edge that changed them.
- Worst-case latency from write to start bit is one cycle plus the remaining frames ahead of the byte.

## Test plan
1. **Reset:** assert `rst` mid-frame -> `tx_out`=1 immediately; `busy`=0 and `full`=0 after release; no further frames.
2. **Burst write:** `din`=0x41 ('A') with `wen`=1 for one cycle, then 0x42 ('B') the next cycle, then `wen`=0.
   - First frame on `tx_out`: 0,1,0,0,0,0,0,1,0,1, each bit 1085 cycles (8680 ns at 8 ns clock).
   - Immediately after, the second frame: 0,0,1,0,0,0,0,1,0,1.
   - `tx_out` then idles at 1 and `busy` falls after 20·N cycles.
3. **Single byte 0x55:** start bit begins exactly one cycle after the write edge; frame is 0,1,0,1,0,1,0,1,0,1.
4. **Overflow:** write 20 bytes 0x00..0x13 on consecutive cycles with `FIFO_DEPTH`=16.
   - The first byte is popped one cycle after it is written, which frees one slot. Bytes 0x00..0x10 are transmitted in order; 0x11..0x13 are dropped.
   - `full` asserts while 16 bytes remain queued.
5. **Wrap-around:** repeated fill/drain cycles exceeding 2·`FIFO_DEPTH` writes -> all bytes are transmitted in order with no corruption.
6. **Write during STOP of last byte:** write 0x0F during the final stop bit -> its start bit follows the stop bit with no idle gap or one cycle after it, and the frame is correct.
